// File: rtl/csr_counter_unit.sv
// Zicntr/Zihpm counter CSR block: cycle, instret and NUM_HPM event counters with
// machine-mode write access, per-counter inhibit and a registered read port.
module csr_counter_unit #(
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pipe_enable,
    input  logic                  instret_valid,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_read_en,
    input  logic [1:0]            csr_op,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal
);

    localparam int          HPM_N      = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [63:0] INH_MASK64 = 64'h5 | (((64'h1 << NUM_HPM) - 64'h1) << 3);
    localparam logic [31:0] INH_MASK   = INH_MASK64[31:0];

    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instret_cnt;
    logic [CNT_WIDTH-1:0] hpm_cnt [HPM_N];
    logic [4:0]           hpm_sel [HPM_N];
    logic [31:0]          inhibit;

    logic        ro, hi, is_cnt, cnt_ok, is_hpm_idx, is_inh, is_evt;
    logic        access, legal, wr_en, wr_cnt;
    logic [4:0]  idx, hpm_idx, evt_idx;
    logic [31:0] old_val, wval, ev_ext;
    logic [HPM_N-1:0] hpm_inc;

    function automatic logic [31:0] cnt_half(input logic [CNT_WIDTH-1:0] c, input logic h);
        logic [63:0] c64;
        c64 = 64'(c);
        return h ? c64[63:32] : c64[31:0];
    endfunction

    // Low-half write drops the increment; high-half write still takes the low-half carry.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic inc, input logic wr_lo,
                                                      input logic wr_hi, input logic [31:0] wv);
        logic [63:0] c64, r;
        c64 = 64'(cur);
        if (wr_lo)
            r = {c64[63:32], wv};
        else if (wr_hi)
            r = {wv, c64[31:0]} + 64'(inc);
        else
            r = c64 + 64'(inc);
        return r[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [4:0] warl_event(input logic [31:0] v);
        return (v > 32'(NUM_EVENTS)) ? 5'd0 : v[4:0];
    endfunction

    always_comb begin
        ro         = (csr_addr[11:8] == 4'hC);
        hi         = csr_addr[7];
        idx        = csr_addr[4:0];
        is_cnt     = (csr_addr[11:8] == 4'hB || ro) && (csr_addr[6:5] == 2'b00);
        hpm_idx    = idx - 5'd3;
        is_hpm_idx = ({1'b0, idx} >= 6'd3) && ({1'b0, idx} < 6'(3 + NUM_HPM));
        cnt_ok     = is_cnt && (idx == 5'd0 || (idx == 5'd1 && ro) || idx == 5'd2 || is_hpm_idx);
        is_inh     = (csr_addr == 12'h320);
        is_evt     = (csr_addr >= 12'h323) && (csr_addr < 12'(12'h323 + NUM_HPM));
        evt_idx    = 5'(csr_addr - 12'h323);
        access     = pipe_enable && (csr_read_en || csr_op != 2'b00);
        legal      = (cnt_ok && !(ro && csr_op != 2'b00)) || is_inh || is_evt;
        wr_en      = pipe_enable && (csr_op != 2'b00) && legal;
        wr_cnt     = wr_en && is_cnt;

        old_val = 32'd0;
        if (cnt_ok) begin
            if (idx == 5'd0 || idx == 5'd1)
                old_val = cnt_half(cycle_cnt, hi);
            else if (idx == 5'd2)
                old_val = cnt_half(instret_cnt, hi);
            else
                for (int i = 0; i < NUM_HPM; i++)
                    if (hpm_idx == 5'(i)) old_val = cnt_half(hpm_cnt[i], hi);
        end else if (is_inh) begin
            old_val = inhibit;
        end else if (is_evt) begin
            for (int i = 0; i < NUM_HPM; i++)
                if (evt_idx == 5'(i)) old_val = {27'd0, hpm_sel[i]};
        end

        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = old_val | csr_wdata;
            2'b11:   wval = old_val & ~csr_wdata;
            default: wval = old_val;
        endcase

        ev_ext  = 32'(event_i);
        hpm_inc = '0;
        for (int i = 0; i < NUM_HPM; i++)
            hpm_inc[i] = pipe_enable && !inhibit[3+i] && (hpm_sel[i] != 5'd0)
                         && ev_ext[hpm_sel[i] - 5'd1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            inhibit     <= '0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
            for (int i = 0; i < HPM_N; i++) begin
                hpm_cnt[i] <= '0;
                hpm_sel[i] <= '0;
            end
        end else begin
            cycle_cnt   <= cnt_next(cycle_cnt, !inhibit[0],
                                    wr_cnt && idx == 5'd0 && !hi, wr_cnt && idx == 5'd0 && hi, wval);
            instret_cnt <= cnt_next(instret_cnt, instret_valid && pipe_enable && !inhibit[2],
                                    wr_cnt && idx == 5'd2 && !hi, wr_cnt && idx == 5'd2 && hi, wval);
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_cnt[i] <= cnt_next(hpm_cnt[i], hpm_inc[i],
                                       wr_cnt && is_hpm_idx && hpm_idx == 5'(i) && !hi,
                                       wr_cnt && is_hpm_idx && hpm_idx == 5'(i) && hi, wval);
                if (wr_en && is_evt && evt_idx == 5'(i))
                    hpm_sel[i] <= warl_event(wval);
            end
            if (wr_en && is_inh)
                inhibit <= wval & INH_MASK;
            // Read port returns the pre-write value and holds while the pipe is stalled.
            if (pipe_enable) begin
                csr_rdata   <= (csr_read_en && legal) ? old_val : 32'd0;
                csr_illegal <= access && !legal;
            end
        end
    end

endmodule
